// File: rtl/demux16x1_wb.sv
// demux16x1_wb: write-back demux into a 16-entry register file.
// A one-deep staging register holds each write for one cycle before it
// is committed. Both read ports forward the staged value.
// Ports: CLK, RST_n (async, active low); WB_in/WB_sel/WB_valid/WB_ready
// write handshake; WB_stall holds the staging register; WB_pending
// one-hot of the staged index; RD_selA/B with REG_OUT_A/B read ports.
// Option: `define ZERO_R0_EN makes reg[0] a constant zero.
module demux16x1_wb #(
    parameter int TAM  = 16,
    parameter int NREG = 16
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic [TAM-1:0]  WB_in,
    input  logic [3:0]      WB_sel,
    input  logic            WB_valid,
    output logic            WB_ready,
    input  logic            WB_stall,
    output logic [NREG-1:0] WB_pending,
    input  logic [3:0]      RD_selA,
    input  logic [3:0]      RD_selB,
    output logic [TAM-1:0]  REG_OUT_A,
    output logic [TAM-1:0]  REG_OUT_B
);

    logic            stage_valid;
    logic            stage_valid_nxt;
    logic [3:0]      stage_sel;
    logic [TAM-1:0]  stage_data;
    logic [TAM-1:0]  regs [NREG];
    logic            capture;
    logic            commit;
    logic [NREG-1:0] we;
    logic            fwd_a;
    logic            fwd_b;

    // State register: stage_valid is the IDLE/STAGED state bit.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            stage_valid <= 1'b0;
            stage_sel   <= '0;
            stage_data  <= '0;
        end else begin
            stage_valid <= stage_valid_nxt;
            if (capture) begin
                stage_sel  <= WB_sel;
                stage_data <= WB_in;
            end
        end
    end

    // Next-state logic. A stalled stage blocks both commit and capture.
    always_comb begin
        commit  = stage_valid & ~WB_stall;
        capture = WB_valid & (~stage_valid | ~WB_stall);
`ifdef ZERO_R0_EN
        // Writes to r0 complete the handshake but are discarded.
        capture = capture & (WB_sel != 4'd0);
`endif
        stage_valid_nxt = capture | (stage_valid & WB_stall);
    end

    // Output logic: handshake, pending mask, write decode, read ports.
    always_comb begin
        WB_ready   = ~stage_valid | ~WB_stall;
        WB_pending = '0;
        we         = '0;
        for (int i = 0; i < NREG; i++) begin
            WB_pending[i] = stage_valid & (stage_sel == 4'(i));
            we[i]         = commit & (stage_sel == 4'(i));
        end
`ifdef ZERO_R0_EN
        we[0] = 1'b0;
`endif
        fwd_a = stage_valid & (stage_sel == RD_selA);
        fwd_b = stage_valid & (stage_sel == RD_selB);
        REG_OUT_A = fwd_a ? stage_data : regs[RD_selA];
        REG_OUT_B = fwd_b ? stage_data : regs[RD_selB];
`ifdef ZERO_R0_EN
        if (RD_selA == 4'd0) REG_OUT_A = '0;
        if (RD_selB == 4'd0) REG_OUT_B = '0;
`endif
    end

    // Register array; at most one entry is written per commit.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (we[i]) regs[i] <= stage_data;
            end
        end
    end

endmodule

// File: tb/tb_demux16x1_wb.sv
// tb_demux16x1_wb: directed bench for demux16x1_wb.
// Expectations are queued at drive time and popped at each sample point.
module tb_demux16x1_wb;

    logic        CLK;
    logic        RST_n;
    logic [15:0] WB_in;
    logic [3:0]  WB_sel;
    logic        WB_valid;
    logic        WB_ready;
    logic        WB_stall;
    logic [15:0] WB_pending;
    logic [3:0]  RD_selA;
    logic [3:0]  RD_selB;
    logic [15:0] REG_OUT_A;
    logic [15:0] REG_OUT_B;

    int compared;
    int mismatched;

    typedef struct {
        string       tag;
        logic [15:0] val;
    } exp_t;

    exp_t sb[$];

    demux16x1_wb #(.TAM(16), .NREG(16)) dut (
        .CLK(CLK), .RST_n(RST_n),
        .WB_in(WB_in), .WB_sel(WB_sel),
        .WB_valid(WB_valid), .WB_ready(WB_ready),
        .WB_stall(WB_stall), .WB_pending(WB_pending),
        .RD_selA(RD_selA), .RD_selB(RD_selB),
        .REG_OUT_A(REG_OUT_A), .REG_OUT_B(REG_OUT_B)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic push(input string t, input logic [15:0] v);
        exp_t e;
        e.tag = t;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic pop_check(input logic [15:0] obs);
        exp_t e;
        compared++;
        if (sb.size() == 0) begin
            mismatched++;
            $error("FAIL sb_empty: observed %h required an expectation", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                mismatched++;
                $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] s,
                         input logic [15:0] d);
        WB_valid = v;
        WB_sel   = s;
        WB_in    = d;
    endtask

    logic [15:0] r0_exp;
    logic [15:0] r0_pend;

    initial begin
        compared   = 0;
        mismatched = 0;
        RST_n    = 1'b0;
        WB_in    = '0;
        WB_sel   = '0;
        WB_valid = 1'b0;
        WB_stall = 1'b0;
        RD_selA  = '0;
        RD_selB  = '0;
`ifdef ZERO_R0_EN
        r0_exp  = 16'h0000;
        r0_pend = 16'h0000;
`else
        r0_exp  = 16'h1234;
        r0_pend = 16'h0001;
`endif
        #3;
        push("rst_pending", 16'h0000);
        push("rst_ready", 16'h0001);
        pop_check(WB_pending);
        pop_check({15'd0, WB_ready});
        for (int i = 0; i < 16; i++) begin
            RD_selA = 4'(i);
            RD_selB = 4'(15 - i);
            #1;
            push("rst_rd_a", 16'h0000);
            push("rst_rd_b", 16'h0000);
            pop_check(REG_OUT_A);
            pop_check(REG_OUT_B);
        end
        @(negedge CLK);
        RST_n = 1'b1;

        // single write to r5
        tick();
        drive(1'b1, 4'd5, 16'hBEEF);
        RD_selA = 4'd5;
        push("w5_fwd_a", 16'hBEEF);
        push("w5_pending", 16'h0020);
        tick();
        pop_check(REG_OUT_A);
        pop_check(WB_pending);
        drive(1'b0, 4'd0, 16'h0000);
        push("w5_array_a", 16'hBEEF);
        push("w5_pending_clr", 16'h0000);
        tick();
        pop_check(REG_OUT_A);
        pop_check(WB_pending);
        for (int i = 0; i < 16; i++) begin
            if (i != 5) begin
                RD_selB = 4'(i);
                #1;
                push("w5_others", 16'h0000);
                pop_check(REG_OUT_B);
            end
        end

        // back-to-back writes
        RD_selA = 4'd3;
        RD_selB = 4'd7;
        drive(1'b1, 4'd3, 16'h1111);
        push("b2b_a1", 16'h1111);
        push("b2b_b1", 16'h0000);
        tick();
        pop_check(REG_OUT_A);
        pop_check(REG_OUT_B);
        drive(1'b1, 4'd3, 16'h2222);
        push("b2b_a2", 16'h2222);
        push("b2b_pend2", 16'h0008);
        tick();
        pop_check(REG_OUT_A);
        pop_check(WB_pending);
        drive(1'b1, 4'd7, 16'h3333);
        push("b2b_a3", 16'h2222);
        push("b2b_b3", 16'h3333);
        push("b2b_pend3", 16'h0080);
        tick();
        pop_check(REG_OUT_A);
        pop_check(REG_OUT_B);
        pop_check(WB_pending);
        drive(1'b0, 4'd0, 16'h0000);
        push("b2b_fin_a", 16'h2222);
        push("b2b_fin_b", 16'h3333);
        push("b2b_fin_pend", 16'h0000);
        tick();
        pop_check(REG_OUT_A);
        pop_check(REG_OUT_B);
        pop_check(WB_pending);

        // stall while a second request waits
        RD_selA = 4'd9;
        RD_selB = 4'd10;
        drive(1'b1, 4'd9, 16'hA5A5);
        push("st_pend0", 16'h0200);
        tick();
        pop_check(WB_pending);
        WB_stall = 1'b1;
        drive(1'b1, 4'd10, 16'h5A5A);
        #1;
        push("st_ready_comb", 16'h0000);
        pop_check({15'd0, WB_ready});
        for (int k = 0; k < 3; k++) begin
            push("st_ready", 16'h0000);
            push("st_pend", 16'h0200);
            push("st_a", 16'hA5A5);
            push("st_b", 16'h0000);
            tick();
            pop_check({15'd0, WB_ready});
            pop_check(WB_pending);
            pop_check(REG_OUT_A);
            pop_check(REG_OUT_B);
        end
        WB_stall = 1'b0;
        #1;
        push("st_release_ready", 16'h0001);
        pop_check({15'd0, WB_ready});
        push("st_rel_pend", 16'h0400);
        push("st_rel_a", 16'hA5A5);
        push("st_rel_b", 16'h5A5A);
        tick();
        pop_check(WB_pending);
        pop_check(REG_OUT_A);
        pop_check(REG_OUT_B);
        drive(1'b0, 4'd0, 16'h0000);
        push("st_done_pend", 16'h0000);
        push("st_done_b", 16'h5A5A);
        tick();
        pop_check(WB_pending);
        pop_check(REG_OUT_B);

        // reset while a write is staged
        RD_selA = 4'd12;
        RD_selB = 4'd9;
        drive(1'b1, 4'd12, 16'hFFFF);
        push("rs_fwd", 16'hFFFF);
        push("rs_pend", 16'h1000);
        tick();
        pop_check(REG_OUT_A);
        pop_check(WB_pending);
        drive(1'b0, 4'd0, 16'h0000);
        #2;
        RST_n = 1'b0;
        #1;
        push("rs_async_a", 16'h0000);
        push("rs_async_b", 16'h0000);
        push("rs_async_pend", 16'h0000);
        push("rs_async_ready", 16'h0001);
        pop_check(REG_OUT_A);
        pop_check(REG_OUT_B);
        pop_check(WB_pending);
        pop_check({15'd0, WB_ready});
        @(negedge CLK);
        RST_n = 1'b1;
        push("rs_after_a", 16'h0000);
        push("rs_after_pend", 16'h0000);
        tick();
        pop_check(REG_OUT_A);
        pop_check(WB_pending);

        // write to index 0
        RD_selA = 4'd0;
        RD_selB = 4'd0;
        drive(1'b1, 4'd0, 16'h1234);
        #1;
        push("r0_ready", 16'h0001);
        pop_check({15'd0, WB_ready});
        push("r0_pend", r0_pend);
        push("r0_fwd_a", r0_exp);
        tick();
        pop_check(WB_pending);
        pop_check(REG_OUT_A);
        drive(1'b0, 4'd0, 16'h0000);
        push("r0_arr_a", r0_exp);
        push("r0_arr_b", r0_exp);
        push("r0_pend_clr", 16'h0000);
        tick();
        pop_check(REG_OUT_A);
        pop_check(REG_OUT_B);
        pop_check(WB_pending);

        compared++;
        assert (sb.size() == 0) else begin
            mismatched++;
            $error("FAIL sb_leftover: observed %0d required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule

// File: doc/demux16x1_wb.md
Name: demux16x1_wb

Overview:
- Write-back side of the 16-register datapath: takes one result word plus a 4-bit destination select and demultiplexes it into one of 16 TAM-bit registers.
- Holds the write for one cycle in a staging register, then commits it to the register array.
- Provides two read ports (A, B) that forward the staged value, so the operand muxes always see the newest data.
- Sits between the ALU result bus and the operand muxes feeding A_ULA/B_ULA.

Parameters:
- TAM, 16, data width of every register and of the write/read buses.
- NREG, 16, number of registers; fixed at 16, matching the 4-bit select.

Ports:
- CLK  input  1  rising-edge clock
- RST_n  input  1  asynchronous reset, active low
- WB_in  input  TAM  write-back data
- WB_sel  input  4  destination register index
- WB_valid  input  1  write request
- WB_ready  output  1  request accepted this cycle when high together with WB_valid
- WB_stall  input  1  freezes the staging register (commit blocked)
- WB_pending  output  16  one-hot of the staged destination; all zero when nothing is staged
- RD_selA  input  4  read port A index
- RD_selB  input  4  read port B index
- REG_OUT_A  output  TAM  read port A data
- REG_OUT_B  output  TAM  read port B data

Behaviour:
- Reset (RST_n low, asynchronous): all 16 registers = 0; stage_valid = 0; stage_sel = 0; stage_data = 0. Outputs: WB_pending = 0; WB_ready = 1; REG_OUT_A and REG_OUT_B = 0.
- Reset asserted mid-operation discards any staged write. The release edge is synchronous to CLK.
- WB_ready = ~stage_valid | ~WB_stall (combinational).
- Per-edge staging-register states (two states, IDLE and STAGED, tracked by stage_valid):
  - IDLE, WB_valid=1: capture WB_in/WB_sel; go to STAGED.
  - IDLE, WB_valid=0: stay in IDLE.
  - STAGED, WB_stall=0: commit stage_data to reg[stage_sel]. If WB_valid=1 the same edge captures the new request (back-to-back, one write per cycle sustained); otherwise go to IDLE.
  - STAGED, WB_stall=1: hold everything; no commit; no capture (WB_ready=0).
- Latency:
  - Request at edge N is staged at N and visible on the read ports right after N through forwarding.
  - It is committed to the array at edge N+1 (N+1+k with k stall cycles).
- Demux decode: exactly one register is written per commit. Write enable for reg i = commit & (stage_sel == i). No other register changes.
- Read ports (combinational):
  - REG_OUT_x = stage_data if stage_valid & (stage_sel == RD_selx); otherwise reg[RD_selx].
  - Both ports may select the same index, and both then return the same value.
- Back-to-back writes to the same index: the second overwrites the first. Read forwarding always returns the staged (newest) value.
- WB_pending[i] = stage_valid & (stage_sel == i).
- Widths: no arithmetic; data is passed unmodified; no truncation or extension.

Optional Feature:
- Macro: ZERO_R0_EN
- Defined:
  - reg[0] is constant 0.
  - A request with WB_sel=0 is accepted (handshake unchanged) but dropped: not staged, WB_pending stays 0.
  - Reads of index 0 return 0 on both ports, with no forwarding.
- Undefined: reg[0] is an ordinary register, identical to the other 15.

Test Plan:
- Reset then read all 16 indices on both ports -> every read 0, WB_pending=0, WB_ready=1.
- WB_valid=1, WB_sel=5, WB_in=0xBEEF, one cycle, no stall:
  - REG_OUT_A (RD_selA=5) = 0xBEEF on the cycle after the edge (forwarded), WB_pending=0x0020.
  - After the next edge the value comes from the array and WB_pending=0.
  - All other registers stay 0.
- Back-to-back writes reg3=0x1111, reg3=0x2222, reg7=0x3333 on consecutive cycles, port A on 3 and port B on 7:
  - A shows 0x1111, then 0x2222.
  - B shows 0x3333 once reg7 is staged.
  - Final array: reg3=0x2222, reg7=0x3333.
- Stage reg9=0xA5A5, hold WB_stall=1 for 3 cycles while WB_valid=1 with reg10=0x5A5A:
  - WB_ready=0 and WB_pending=0x0200 throughout; reg10 is not captured.
  - Releasing the stall commits reg9 and captures reg10 on the same edge.
- Stage reg12=0xFFFF, assert RST_n=0 before commit:
  - Outputs go 0 immediately (asynchronously); reg12 reads 0 after release.
- With ZERO_R0_EN defined: write WB_sel=0, WB_in=0x1234 -> WB_ready=1, WB_pending stays 0, reads of index 0 return 0. Without the macro, the same write reads back 0x1234.
